unsolved_token_arbiter: RTL and testbench
=========================================

Name: unsolved_token_arbiter

Overview:
- Sits directly downstream of the per-block RAM modules (NUM_BLOCKS instances) and consumes their unsolved copy-token FIFO outputs.
- Each cycle it selects at most one pending token and pops it from its source with a one-cycle read strobe.
- It tags the token with the source block number and presents it on a single registered valid/ready output to the copy re-issue path.
- Selection is round-robin with priority for half-full sources, plus a starvation guard.

Parameters:
- NUM_BLOCKS, 16: number of RAM modules served.
- TOKEN_W, 33: width of one unsolved token.
- ID_W, 4: width of the source-block tag; must satisfy 2^ID_W >= NUM_BLOCKS.
- STARVE_LIMIT, 8'd32: consecutive urgent-only grants allowed before priority is ignored for one grant.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- page_finish  in  1  end of file; flush.
- unsolved_valid_in  in  NUM_BLOCKS  per-block token present (registered valid from each RAM module).
- unsolved_data_in  in  NUM_BLOCKS*TOKEN_W  per-block tokens; block i occupies bits [i*TOKEN_W +: TOKEN_W].
- unsolved_half_full_in  in  NUM_BLOCKS  per-block FIFO above half-full threshold.
- unsolved_rd  out  NUM_BLOCKS  one-hot pop strobe to block FIFOs.
- tok_valid  out  1  output token valid.
- tok_ready  in  1  downstream accepts.
- tok_data  out  ID_W+TOKEN_W  {source id, token}.
- idle  out  1  no pending input and output register empty.

Behaviour:
- Reset (async, rst=1): tok_valid=0, tok_data=0, unsolved_rd=0, rr_ptr=0, starve_cnt=0; idle follows its combinational definition.
- Slot free: slot_free = ~tok_valid | tok_ready.
- Request vector: req = unsolved_valid_in & ~unsolved_rd_q, where unsolved_rd_q is the previous-cycle strobe. This masks the source's registered-valid update lag so no token is double-popped.
- Urgent set: urg = req & unsolved_half_full_in.
- Class choice:
  - Use urg if urg != 0 and starve_cnt < STARVE_LIMIT; otherwise use req.
  - Within the chosen class, grant the first set bit at or after rr_ptr, wrapping modulo NUM_BLOCKS.
- Grant cycle (slot_free & class != 0):
  - unsolved_rd[g]=1 (combinational, same cycle).
  - On the next edge: tok_data <= {g[ID_W-1:0], token g}; tok_valid <= 1; rr_ptr <= (g+1) mod NUM_BLOCKS.
- Starvation counter:
  - Increments on a grant taken from urg while non-urgent requests are also pending.
  - Resets to 0 on a non-urgent grant, or when no non-urgent request is pending.
  - Saturates at STARVE_LIMIT.
- Latency: token to tok_valid is 1 cycle. Sustained throughput is 1 token/cycle when tok_ready=1, with no bubbles. Back-to-back grants to the same block are impossible (masked one cycle).
- Backpressure: tok_valid=1 & tok_ready=0 → tok_data holds, no unsolved_rd asserted, rr_ptr holds.
- Simultaneous accept and grant: the output register is overwritten on the same edge (pass-through).
- page_finish (synchronous):
  - tok_valid <= 0, unsolved_rd forced 0 that cycle, rr_ptr <= 0, starve_cnt <= 0.
  - Tokens still in the sources are not popped; the sources are cleared by their own page_finish.
- idle = ~tok_valid & ~|unsolved_valid_in.
- Reset mid-transfer: the token in the output register is lost. This is legal only with sources also reset.

Optional Feature:
- UNSOLVED_ARB_STAT_EN.
- Defined:
  - Adds outputs stat_grants (32 bits), counting every unsolved_rd pulse.
  - Adds stat_stall (32 bits), counting cycles with tok_valid & ~tok_ready.
  - Adds stat_starve (16 bits), counting grants forced by the starvation guard.
  - All three clear on rst or page_finish and saturate at all-ones.
- Undefined: these ports and registers do not exist; the arbitration behaviour is identical.

Test Plan:
- After reset, blocks 3, 7, 12 valid, none half-full, tok_ready=1 → one pop per cycle in order 3, 7, 12; tok_data ids 3, 7, 12 on consecutive cycles; idle=1 afterwards.
- Block 5 half-full and block 2 not, both valid, rr_ptr=0 → block 5 granted first, then block 2.
- tok_ready=0 for 10 cycles with 4 blocks valid → exactly one pop, tok_data stable, stat_stall=10 (with UNSOLVED_ARB_STAT_EN); release tok_ready → remaining 3 tokens drain on 3 consecutive cycles.
- Blocks 0 and 1 urgent and refilled every grant, block 9 non-urgent, STARVE_LIMIT=4 → block 9 granted after exactly 4 urgent grants; stat_starve=1.
- Single block 6 holds 5 tokens → pops spaced 2 cycles apart (mask), 5 tokens out, none duplicated.
- page_finish while tok_valid=1 and 3 blocks pending → next cycle tok_valid=0, no unsolved_rd that cycle, rr_ptr=0; assert rst asynchronously mid-stream → tok_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/unsolved_token_arbiter.sv
// Round-robin arbiter that drains the per-block unsolved copy-token FIFOs into one
// registered valid/ready stream. Half-full sources have priority, and a starvation guard bounds that priority.
// Optional statistics counters are enabled with `define UNSOLVED_ARB_STAT_EN.
module unsolved_token_arbiter #(
    parameter int         NUM_BLOCKS   = 16,
    parameter int         TOKEN_W      = 33,
    parameter int         ID_W         = 4,
    parameter logic [7:0] STARVE_LIMIT = 8'd32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          page_finish,
    input  logic [NUM_BLOCKS-1:0]         unsolved_valid_in,
    input  logic [NUM_BLOCKS*TOKEN_W-1:0] unsolved_data_in,
    input  logic [NUM_BLOCKS-1:0]         unsolved_half_full_in,
    output logic [NUM_BLOCKS-1:0]         unsolved_rd,
    output logic                          tok_valid,
    input  logic                          tok_ready,
    output logic [ID_W+TOKEN_W-1:0]       tok_data,
`ifdef UNSOLVED_ARB_STAT_EN
    output logic [31:0]                   stat_grants,
    output logic [31:0]                   stat_stall,
    output logic [15:0]                   stat_starve,
`endif
    output logic                          idle
);

    localparam int PTR_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

    logic [PTR_W-1:0]        rr_ptr_reg;
    logic [PTR_W-1:0]        rr_ptr_next;
    logic [7:0]              starve_cnt_reg;
    logic [7:0]              starve_cnt_next;
    logic [NUM_BLOCKS-1:0]   rd_q_reg;
    logic [ID_W+TOKEN_W-1:0] tok_data_reg;
    logic                    tok_valid_reg;

    logic [TOKEN_W-1:0]      tok_arr [NUM_BLOCKS];
    logic [NUM_BLOCKS-1:0]   req;
    logic [NUM_BLOCKS-1:0]   urg;
    logic [NUM_BLOCKS-1:0]   cls;
    logic                    norm_pend;
    logic                    starve_hit;
    logic                    use_urg;
    logic                    slot_free;
    logic                    grant_found;
    logic [PTR_W-1:0]        grant_idx;
    logic                    grant;
    logic                    forced;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BLOCKS; gi++) begin : g_unpack
            assign tok_arr[gi] = unsolved_data_in[gi*TOKEN_W +: TOKEN_W];
        end
    endgenerate

    // A source popped last cycle still shows its stale registered valid; mask it.
    assign req        = unsolved_valid_in & ~rd_q_reg;
    assign urg        = req & unsolved_half_full_in;
    assign norm_pend  = |(req & ~unsolved_half_full_in);
    assign starve_hit = (starve_cnt_reg >= STARVE_LIMIT);
    assign use_urg    = (|urg) & ~starve_hit;
    assign cls        = use_urg ? urg : req;
    assign slot_free  = ~tok_valid_reg | tok_ready;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NUM_BLOCKS; i++) begin
            int idx;
            idx = (int'(rr_ptr_reg) + i) % NUM_BLOCKS;
            if (!grant_found && cls[idx]) begin
                grant_found = 1'b1;
                grant_idx   = idx[PTR_W-1:0];
            end
        end
    end

    assign grant  = slot_free & grant_found & ~page_finish & ~rst;
    assign forced = grant & (|urg) & starve_hit;

    always_comb begin
        unsolved_rd = '0;
        if (grant) begin
            unsolved_rd[grant_idx] = 1'b1;
        end
    end

    assign rr_ptr_next = (int'(grant_idx) == NUM_BLOCKS - 1) ? '0 : grant_idx + 1'b1;

    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (!norm_pend) begin
            starve_cnt_next = '0;
        end else if (grant) begin
            if (unsolved_half_full_in[grant_idx]) begin
                if (starve_cnt_reg < STARVE_LIMIT) begin
                    starve_cnt_next = starve_cnt_reg + 8'd1;
                end
            end else begin
                starve_cnt_next = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tok_valid_reg  <= 1'b0;
            tok_data_reg   <= '0;
            rr_ptr_reg     <= '0;
            starve_cnt_reg <= '0;
            rd_q_reg       <= '0;
        end else if (page_finish) begin
            tok_valid_reg  <= 1'b0;
            rr_ptr_reg     <= '0;
            starve_cnt_reg <= '0;
            rd_q_reg       <= '0;
        end else begin
            rd_q_reg       <= unsolved_rd;
            starve_cnt_reg <= starve_cnt_next;
            if (grant) begin
                tok_data_reg  <= {ID_W'(grant_idx), tok_arr[grant_idx]};
                tok_valid_reg <= 1'b1;
                rr_ptr_reg    <= rr_ptr_next;
            end else if (tok_ready) begin
                tok_valid_reg <= 1'b0;
            end
        end
    end

    assign tok_valid = tok_valid_reg;
    assign tok_data  = tok_data_reg;
    assign idle      = ~tok_valid_reg & ~(|unsolved_valid_in);

`ifdef UNSOLVED_ARB_STAT_EN
    logic [31:0] stat_grants_reg;
    logic [31:0] stat_stall_reg;
    logic [15:0] stat_starve_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_grants_reg <= '0;
            stat_stall_reg  <= '0;
            stat_starve_reg <= '0;
        end else if (page_finish) begin
            stat_grants_reg <= '0;
            stat_stall_reg  <= '0;
            stat_starve_reg <= '0;
        end else begin
            if (grant && stat_grants_reg != '1) begin
                stat_grants_reg <= stat_grants_reg + 32'd1;
            end
            if (tok_valid_reg && !tok_ready && stat_stall_reg != '1) begin
                stat_stall_reg <= stat_stall_reg + 32'd1;
            end
            if (forced && stat_starve_reg != '1) begin
                stat_starve_reg <= stat_starve_reg + 16'd1;
            end
        end
    end

    assign stat_grants = stat_grants_reg;
    assign stat_stall  = stat_stall_reg;
    assign stat_starve = stat_starve_reg;
`endif

endmodule

// File: tb/tb_unsolved_token_arbiter.sv
// Self-checking bench for unsolved_token_arbiter: modelled source FIFOs, a token scoreboard
// and per-scenario grant-order checks.
module tb_unsolved_token_arbiter;

    localparam int NB = 16;
    localparam int TW = 33;
    localparam int IW = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              page_finish;
    logic [NB-1:0]     valid_in;
    logic [NB*TW-1:0]  data_in;
    logic [NB-1:0]     hf_in;
    logic [NB-1:0]     unsolved_rd;
    logic              tok_valid;
    logic              tok_ready;
    logic [IW+TW-1:0]  tok_data;
    logic              idle;
`ifdef UNSOLVED_ARB_STAT_EN
    logic [31:0]       stat_grants;
    logic [31:0]       stat_stall;
    logic [15:0]       stat_starve;
`endif

    unsolved_token_arbiter #(
        .NUM_BLOCKS(NB), .TOKEN_W(TW), .ID_W(IW), .STARVE_LIMIT(8'd4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .page_finish(page_finish),
        .unsolved_valid_in(valid_in),
        .unsolved_data_in(data_in),
        .unsolved_half_full_in(hf_in),
        .unsolved_rd(unsolved_rd),
        .tok_valid(tok_valid),
        .tok_ready(tok_ready),
        .tok_data(tok_data),
`ifdef UNSOLVED_ARB_STAT_EN
        .stat_grants(stat_grants),
        .stat_stall(stat_stall),
        .stat_starve(stat_starve),
`endif
        .idle(idle)
    );

    always #5 clk = ~clk;

    // Source FIFO model: small circular buffer per block.
    logic [TW-1:0]    src_mem [NB][16];
    int               src_head [NB];
    int               src_cnt [NB];
    logic [NB-1:0]    hf_cfg;

    logic [IW+TW-1:0] sb_q [$];
    int               grant_log [$];
    int               grant_cyc [$];
    int               out_log [$];
    int               errors = 0;
    int               checks = 0;
    int               cyc = 0;

    task automatic drive_sources();
        for (int b = 0; b < NB; b++) begin
            valid_in[b] = (src_cnt[b] > 0);
            data_in[b*TW +: TW] = (src_cnt[b] > 0) ? src_mem[b][src_head[b]] : '0;
        end
        hf_in = hf_cfg;
    endtask

    task automatic add_tok(input int b, input logic [TW-1:0] v);
        src_mem[b][(src_head[b] + src_cnt[b]) % 16] = v;
        src_cnt[b]++;
    endtask

    task automatic clear_all();
        for (int b = 0; b < NB; b++) begin
            src_head[b] = 0;
            src_cnt[b]  = 0;
        end
        hf_cfg = '0;
        sb_q.delete();
        grant_log.delete();
        grant_cyc.delete();
        out_log.delete();
        drive_sources();
    endtask

    function automatic bit sources_empty();
        for (int b = 0; b < NB; b++) begin
            if (src_cnt[b] != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // One clock: observe pops and accepted output, then advance to the next falling edge.
    task automatic cycle();
        logic [NB-1:0]    rd_s;
        logic [IW+TW-1:0] exp_d;
        #1;
        rd_s = unsolved_rd;
        checks++;
        if ($countones(rd_s) > 1) begin
            errors++;
            $display("FAIL rd_onehot cyc=%0d got=%h required at most one bit", cyc, rd_s);
        end
        for (int b = 0; b < NB; b++) begin
            if (rd_s[b]) begin
                checks++;
                if (src_cnt[b] == 0) begin
                    errors++;
                    $display("FAIL rd_empty cyc=%0d block=%0d popped with no token", cyc, b);
                end else begin
                    sb_q.push_back({4'(b), src_mem[b][src_head[b]]});
                    src_head[b] = (src_head[b] + 1) % 16;
                    src_cnt[b]--;
                end
                grant_log.push_back(b);
                grant_cyc.push_back(cyc);
            end
        end
        if (tok_valid && tok_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL tok_unexpected cyc=%0d got=%h required no token", cyc, tok_data);
            end else begin
                exp_d = sb_q.pop_front();
                if (tok_data !== exp_d) begin
                    errors++;
                    $display("FAIL tok_data cyc=%0d got=%h required=%h", cyc, tok_data, exp_d);
                end
            end
            out_log.push_back(int'(tok_data[IW+TW-1:TW]));
            $display("cyc=%0d out id=%0d data=%h", cyc, tok_data[IW+TW-1:TW], tok_data[TW-1:0]);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        drive_sources();
    endtask

    task automatic run_drain(input int max_cyc);
        int n;
        n = 0;
        while ((!sources_empty() || tok_valid || sb_q.size() != 0) && n < max_cyc) begin
            cycle();
            n++;
        end
        checks++;
        if (n >= max_cyc) begin
            errors++;
            $display("FAIL drain_timeout budget=%0d sources_empty=%0d tok_valid=%0d", max_cyc, sources_empty(), tok_valid);
        end
    endtask

    task automatic do_page_finish();
        page_finish = 1'b1;
        cycle();
        page_finish = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (tok_valid !== 1'b0 || unsolved_rd !== '0 || tok_data !== '0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL reset_state tok_valid=%b rd=%h tok_data=%h idle=%b required 0/0/0/1",
                     tok_valid, unsolved_rd, tok_data, idle);
        end
`ifdef UNSOLVED_ARB_STAT_EN
        checks++;
        if (stat_grants !== 32'd0 || stat_stall !== 32'd0 || stat_starve !== 16'd0) begin
            errors++;
            $display("FAIL reset_stats got=%0d/%0d/%0d required 0/0/0", stat_grants, stat_stall, stat_starve);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        $display("reset released");
    endtask

    task automatic test_rr_order();
        clear_all();
        add_tok(3, 33'h0_0000_0003);
        add_tok(7, 33'h1_0000_0007);
        add_tok(12, 33'h0_ABCD_000C);
        drive_sources();
        tok_ready = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        checks++;
        if (grant_log.size() != 3 || grant_log[0] != 3 || grant_log[1] != 7 || grant_log[2] != 12) begin
            errors++;
            $display("FAIL rr_grant_order got size=%0d required 3,7,12", grant_log.size());
        end
        checks++;
        if (grant_cyc.size() != 3 || grant_cyc[1] != grant_cyc[0] + 1 || grant_cyc[2] != grant_cyc[1] + 1) begin
            errors++;
            $display("FAIL rr_consecutive pops not on consecutive cycles");
        end
        checks++;
        if (out_log.size() != 3 || out_log[0] != 3 || out_log[1] != 7 || out_log[2] != 12) begin
            errors++;
            $display("FAIL rr_out_ids got size=%0d required ids 3,7,12", out_log.size());
        end
        #1;
        checks++;
        if (idle !== 1'b1) begin
            errors++;
            $display("FAIL rr_idle got=%b required=1", idle);
        end
    endtask

    task automatic test_urgent();
        clear_all();
        do_page_finish();
        add_tok(5, 33'h0_0000_5555);
        add_tok(2, 33'h0_0000_2222);
        hf_cfg = 16'h0020;
        drive_sources();
        run_drain(20);
        checks++;
        if (grant_log.size() != 2 || grant_log[0] != 5 || grant_log[1] != 2) begin
            errors++;
            $display("FAIL urgent_order got size=%0d first=%0d required 5 then 2",
                     grant_log.size(), grant_log.size() > 0 ? grant_log[0] : -1);
        end
    endtask

    task automatic test_backpressure();
        logic [IW+TW-1:0] held;
        clear_all();
        do_page_finish();
        add_tok(1, 33'h0_0000_1111);
        add_tok(4, 33'h0_0000_4444);
        add_tok(8, 33'h0_0000_8888);
        add_tok(13, 33'h0_0000_DDDD);
        drive_sources();
        tok_ready = 1'b0;
        held = {4'd1, 33'h0_0000_1111};
        for (int i = 0; i < 11; i++) begin
            cycle();
            checks++;
            if (tok_valid !== 1'b1 || tok_data !== held) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d valid=%b data=%h required 1/%h", cyc, tok_valid, tok_data, held);
            end
        end
        checks++;
        if (grant_log.size() != 1) begin
            errors++;
            $display("FAIL bp_single_pop got=%0d pops required=1", grant_log.size());
        end
`ifdef UNSOLVED_ARB_STAT_EN
        checks++;
        if (stat_stall !== 32'd10) begin
            errors++;
            $display("FAIL bp_stat_stall got=%0d required=10", stat_stall);
        end
`endif
        tok_ready = 1'b1;
        run_drain(20);
        checks++;
        if (grant_log.size() != 4 || grant_log[1] != 4 || grant_log[2] != 8 || grant_log[3] != 13 ||
            grant_cyc[2] != grant_cyc[1] + 1 || grant_cyc[3] != grant_cyc[2] + 1) begin
            errors++;
            $display("FAIL bp_release remaining pops not 4,8,13 on consecutive cycles (size=%0d)", grant_log.size());
        end
    endtask

    task automatic test_starvation();
        int exp_seq [5];
        exp_seq = '{0, 1, 0, 1, 9};
        clear_all();
        do_page_finish();
        for (int k = 0; k < 6; k++) begin
            add_tok(0, 33'(32'h0A00 + k));
            add_tok(1, 33'(32'h0B00 + k));
        end
        add_tok(9, 33'h1_0000_0999);
        hf_cfg = 16'h0003;
        drive_sources();
        run_drain(60);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (grant_log.size() <= i || grant_log[i] != exp_seq[i]) begin
                errors++;
                $display("FAIL starve_order idx=%0d got=%0d required=%0d", i,
                         grant_log.size() > i ? grant_log[i] : -1, exp_seq[i]);
            end
        end
`ifdef UNSOLVED_ARB_STAT_EN
        checks++;
        if (stat_starve !== 16'd1 || stat_grants !== 32'd13) begin
            errors++;
            $display("FAIL starve_stats starve=%0d grants=%0d required 1/13", stat_starve, stat_grants);
        end
`endif
    endtask

    task automatic test_mask();
        bit spacing_ok;
        clear_all();
        do_page_finish();
        for (int k = 0; k < 5; k++) add_tok(6, 33'(32'h6000 + k));
        drive_sources();
        run_drain(40);
        spacing_ok = (grant_cyc.size() == 5);
        for (int i = 1; i < grant_cyc.size(); i++) begin
            if (grant_cyc[i] != grant_cyc[i-1] + 2) spacing_ok = 1'b0;
        end
        checks++;
        if (!spacing_ok) begin
            errors++;
            $display("FAIL mask_spacing pops=%0d required 5 pops two cycles apart", grant_cyc.size());
        end
        checks++;
        if (out_log.size() != 5) begin
            errors++;
            $display("FAIL mask_count got=%0d tokens required=5", out_log.size());
        end
    endtask

    task automatic test_page_finish();
        clear_all();
        do_page_finish();
        add_tok(9, 33'h0_0000_9999);
        add_tok(2, 33'h0_0000_2222);
        add_tok(10, 33'h0_0000_AAAA);
        add_tok(14, 33'h0_0000_EEEE);
        hf_cfg = 16'h0200;
        drive_sources();
        tok_ready = 1'b0;
        cycle();
        page_finish = 1'b1;
        #1;
        checks++;
        if (unsolved_rd !== '0 || tok_valid !== 1'b1) begin
            errors++;
            $display("FAIL pf_same_cycle rd=%h valid=%b required rd=0 valid=1", unsolved_rd, tok_valid);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        page_finish = 1'b0;
        checks++;
        if (tok_valid !== 1'b0) begin
            errors++;
            $display("FAIL pf_flush tok_valid=%b required=0", tok_valid);
        end
        sb_q.delete();
        grant_log.delete();
        grant_cyc.delete();
        tok_ready = 1'b1;
        run_drain(20);
        checks++;
        if (grant_log.size() != 3 || grant_log[0] != 2 || grant_log[1] != 10 || grant_log[2] != 14) begin
            errors++;
            $display("FAIL pf_rr_reset first grant=%0d required 2,10,14",
                     grant_log.size() > 0 ? grant_log[0] : -1);
        end
    endtask

    task automatic test_async_reset();
        clear_all();
        add_tok(3, 33'h0_0000_3333);
        add_tok(4, 33'h0_0000_4444);
        drive_sources();
        tok_ready = 1'b0;
        cycle();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (tok_valid !== 1'b0 || unsolved_rd !== '0) begin
            errors++;
            $display("FAIL async_reset tok_valid=%b rd=%h required 0/0 before clock edge", tok_valid, unsolved_rd);
        end
        @(posedge clk);
        @(negedge clk);
        clear_all();
        rst = 1'b0;
        #1;
        checks++;
        if (idle !== 1'b1) begin
            errors++;
            $display("FAIL async_reset_idle got=%b required=1", idle);
        end
    endtask

    initial begin
        rst = 1'b1;
        page_finish = 1'b0;
        tok_ready = 1'b1;
        valid_in = '0;
        data_in = '0;
        hf_in = '0;
        clear_all();
        test_reset();
        test_rr_order();
        test_urgent();
        test_backpressure();
        test_starvation();
        test_mask();
        test_page_finish();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
